// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
// Holds the requester-ID width rule and the default operand bundle.
package adder_share_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_A_WIDTH = 16;
   localparam int DEF_B_WIDTH = 16;
   localparam int RESET_PTR   = 0;

   // A one-bit ID is still needed for two requesters.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // One request: operands plus the issuing requester index.
   typedef struct packed {
      logic signed [DEF_A_WIDTH-1:0]           a;
      logic signed [DEF_B_WIDTH-1:0]           b;
      logic [id_width(DEF_NUM_REQ)-1:0]        id;
   } op_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/result bundle between the requesters and the shared adder.
// master = requester side, slave = arbiter side.
interface adder_share_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int OUT_WIDTH = 17,
   parameter int ID_WIDTH  = 2
);

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*A_WIDTH-1:0]  req_a;
   logic [NUM_REQ*B_WIDTH-1:0]  req_b;
   logic                        res_valid;
   logic                        res_ready;
   logic signed [OUT_WIDTH-1:0] res_data;
   logic [ID_WIDTH-1:0]         res_id;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_id
   );

endinterface

// File: rtl/adder_share_arbiter_adder.sv
// Signed adder: sign-extend both operands to the full sum width,
// add, arithmetic shift right, then truncate without saturation.
module adder #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int OUT_SCALE = 0,
   parameter int OUT_WIDTH = 17
) (
   input  logic signed [A_WIDTH-1:0]   a,
   input  logic signed [B_WIDTH-1:0]   b,
   output logic signed [OUT_WIDTH-1:0] out
);

   localparam int SW = A_WIDTH + B_WIDTH;

   logic signed [SW-1:0] ax;
   logic signed [SW-1:0] bx;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] shifted;

   // Full-width sum can never overflow, so only the final cut wraps.
   always_comb begin
      ax      = {{B_WIDTH{a[A_WIDTH-1]}}, a};
      bx      = {{A_WIDTH{b[B_WIDTH-1]}}, b};
      sum     = ax + bx;
      shifted = sum >>> OUT_SCALE;
      out     = OUT_WIDTH'(shifted);
   end

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin grant search starting at ptr, wrapping to index 0.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   input  logic                advance,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_id,
   output logic [ID_WIDTH-1:0] ptr_next
);

   logic found;

   // First asserted request at or after ptr, scanning with wrap.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_WIDTH'(idx);
         end
      end
   end

   // Pointer moves past the winner only when its handshake completes.
   always_comb begin
      ptr_next = ptr;
      if (advance) begin
         if (grant_id == ID_WIDTH'(NUM_REQ - 1))
            ptr_next = '0;
         else
            ptr_next = grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one signed adder between NUM_REQ valid/ready requesters:
// round-robin grant -> operand register -> adder -> result register.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int OUT_SCALE = 0,
   parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
   parameter int ID_WIDTH  = id_width(NUM_REQ)
) (
   input logic                  clk,
   input logic                  arst_n_in,
   adder_share_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0]          grant;
   logic [ID_WIDTH-1:0]         grant_id;
   logic [ID_WIDTH-1:0]         ptr;
   logic [ID_WIDTH-1:0]         ptr_next;
   logic                        fire;
   logic                        s1_accept;
   logic                        s2_accept;
   logic signed [A_WIDTH-1:0]   a_sel;
   logic signed [B_WIDTH-1:0]   b_sel;
   logic                        s1_valid;
   logic signed [A_WIDTH-1:0]   s1_a;
   logic signed [B_WIDTH-1:0]   s1_b;
   logic [ID_WIDTH-1:0]         s1_id;
   logic signed [OUT_WIDTH-1:0] sum;
   logic                        res_valid;
   logic signed [OUT_WIDTH-1:0] res_data;
   logic [ID_WIDTH-1:0]         res_id;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req      (bus.req_valid),
      .ptr      (ptr),
      .advance  (fire),
      .grant    (grant),
      .grant_id (grant_id),
      .ptr_next (ptr_next)
   );

   assign s2_accept = !res_valid || bus.res_ready;
   assign s1_accept = !s1_valid || s2_accept;

   // Ready is forced low during reset even though s1 is empty then.
   assign bus.req_ready = arst_n_in ? (grant & {NUM_REQ{s1_accept}}) : '0;
   assign fire          = |(bus.req_valid & bus.req_ready);

   // Operand mux follows the granted slot.
   always_comb begin
      a_sel = bus.req_a[grant_id*A_WIDTH +: A_WIDTH];
      b_sel = bus.req_b[grant_id*B_WIDTH +: B_WIDTH];
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in)
         ptr <= ID_WIDTH'(RESET_PTR);
      else
         ptr <= ptr_next;
   end

   // Stage 1: operand register; a new grant may refill it as it drains.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else if (fire) begin
         s1_valid <= 1'b1;
         s1_a     <= a_sel;
         s1_b     <= b_sel;
         s1_id    <= grant_id;
      end else if (s2_accept) begin
         s1_valid <= 1'b0;
      end
   end

   adder #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .OUT_SCALE (OUT_SCALE),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_adder (
      .a   (s1_a),
      .b   (s1_b),
      .out (sum)
   );

   // Stage 2: result register, held while downstream stalls.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else if (s2_accept) begin
         res_valid <= s1_valid;
         if (s1_valid) begin
            res_data <= sum;
            res_id   <= s1_id;
         end
      end
   end

   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_id    = res_id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: vector table for single ops,
// hand-written sequences for rotation, wrap, stall and reset cases.
module tb_adder_share_arbiter;
   import adder_share_pkg::*;

   logic clk = 1'b0;
   logic arst_n;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adder_share_arbiter_if #(
      .NUM_REQ(4), .A_WIDTH(16), .B_WIDTH(16),
      .OUT_WIDTH(17), .ID_WIDTH(2)
   ) bus ();

   adder_share_arbiter_if #(
      .NUM_REQ(4), .A_WIDTH(16), .B_WIDTH(16),
      .OUT_WIDTH(17), .ID_WIDTH(2)
   ) bus1 ();

   adder_share_arbiter #(
      .NUM_REQ(4), .A_WIDTH(16), .B_WIDTH(16), .OUT_SCALE(0)
   ) dut (
      .clk       (clk),
      .arst_n_in (arst_n),
      .bus       (bus)
   );

   adder_share_arbiter #(
      .NUM_REQ(4), .A_WIDTH(16), .B_WIDTH(16), .OUT_SCALE(1)
   ) dut_s1 (
      .clk       (clk),
      .arst_n_in (arst_n),
      .bus       (bus1)
   );

   typedef struct {
      op_t                op;
      logic signed [16:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0] pat [3];
      logic [3:0] oh;
      int         hs;
      int         id;

      vecs[0] = '{'{a: 16'sd100,  b: -16'sd30,  id: 2'd0}, 17'sd70};
      vecs[1] = '{'{a: 16'sd32767, b: 16'sd32767, id: 2'd1}, 17'sd65534};
      vecs[2] = '{'{a: 16'h8000,   b: 16'h8000,   id: 2'd2}, -17'sd65536};
      vecs[3] = '{'{a: -16'sd5,    b: 16'sd3,     id: 2'd0}, -17'sd2};
      vecs[4] = '{'{a: -16'sd1,    b: 16'sd1,     id: 2'd2}, 17'sd0};
      vecs[5] = '{'{a: 16'sd1234,  b: -16'sd2000, id: 2'd3}, -17'sd766};

      pat[0] = 4'b1111;
      pat[1] = 4'b0101;
      pat[2] = 4'b1010;

      arst_n         = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.res_ready  = 1'b1;
      bus1.req_valid = '0;
      bus1.req_a     = '0;
      bus1.req_b     = '0;
      bus1.res_ready = 1'b1;

      // Reset holds everything quiet whatever the inputs do.
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.req_valid = pat[i];
         bus.req_a     = {4{16'(i * 77)}};
         bus.res_ready = i[0];
         #1;
         check("rst_ready", longint'(bus.req_ready), 0);
         check("rst_res_valid", longint'(bus.res_valid), 0);
      end
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.res_ready = 1'b1;
      tick();
      arst_n = 1'b1;
      bus.req_valid = 4'b0001;
      #1;
      check("post_rst_ready", longint'(bus.req_ready), 1);
      bus.req_valid = '0;
      tick();

      // Single operations from the table, two-cycle latency.
      for (int i = 0; i < 6; i++) begin
         id = int'(vecs[i].op.id);
         oh = 4'b0001 << id;
         bus.req_valid = oh;
         bus.req_a[id*16 +: 16] = vecs[i].op.a;
         bus.req_b[id*16 +: 16] = vecs[i].op.b;
         #1;
         check("vec_ready", longint'(bus.req_ready), longint'(oh));
         tick();
         bus.req_valid = '0;
         check("vec_early", longint'(bus.res_valid), 0);
         tick();
         check("vec_valid", longint'(bus.res_valid), 1);
         check("vec_data", longint'(bus.res_data), longint'(vecs[i].exp));
         check("vec_id", longint'(bus.res_id), longint'(id));
         tick();
         check("vec_drain", longint'(bus.res_valid), 0);
      end

      // Arithmetic shift on the scaled instance: floor division by 2.
      bus1.req_valid = 4'b0001;
      bus1.req_a[15:0] = 16'sd7;
      bus1.req_b[15:0] = 16'sd2;
      tick();
      bus1.req_a[15:0] = -16'sd7;
      tick();
      bus1.req_valid = '0;
      check("scale_pos", longint'(bus1.res_data), 4);
      check("scale_pos_v", longint'(bus1.res_valid), 1);
      tick();
      check("scale_neg", longint'(bus1.res_data), -3);
      tick();
      check("scale_drain", longint'(bus1.res_valid), 0);

      // Strict rotation with everybody valid, one result per cycle.
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*16 +: 16] = 16'(i * 1000);
         bus.req_b[i*16 +: 16] = 16'(i);
      end
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         check("rr_ready", longint'(bus.req_ready),
               longint'(4'b0001 << (c % 4)));
         tick();
         if (c >= 1) begin
            check("rr_valid", longint'(bus.res_valid), 1);
            check("rr_id", longint'(bus.res_id), longint'((c - 1) % 4));
            check("rr_data", longint'(bus.res_data),
                  longint'(((c - 1) % 4) * 1001));
         end
      end
      bus.req_valid = '0;
      tick();
      check("rr_last_id", longint'(bus.res_id), 3);
      tick();
      check("rr_drain", longint'(bus.res_valid), 0);

      // Wrap: grant 2 leaves ptr at 3, then 0 and 1 win in turn.
      bus.req_valid = 4'b0100;
      #1;
      check("wrap_g2", longint'(bus.req_ready), 4);
      tick();
      bus.req_valid = 4'b0011;
      #1;
      check("wrap_g0", longint'(bus.req_ready), 1);
      tick();
      check("wrap_r2", longint'(bus.res_id), 2);
      check("wrap_g1", longint'(bus.req_ready), 2);
      tick();
      bus.req_valid = '0;
      check("wrap_r0", longint'(bus.res_id), 0);
      tick();
      check("wrap_r1", longint'(bus.res_id), 1);
      tick();
      check("wrap_drain", longint'(bus.res_valid), 0);

      // Stall: only two handshakes fit before all ready drop.
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b1111;
      hs = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (|(bus.req_valid & bus.req_ready))
            hs++;
         if (c >= 2)
            check("bp_ready", longint'(bus.req_ready), 0);
         tick();
         if (c >= 1) begin
            check("bp_hold_id", longint'(bus.res_id), 2);
            check("bp_hold_data", longint'(bus.res_data), 2002);
         end
      end
      check("bp_handshakes", longint'(hs), 2);
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      tick();
      check("bp_next_valid", longint'(bus.res_valid), 1);
      check("bp_next_id", longint'(bus.res_id), 3);
      check("bp_next_data", longint'(bus.res_data), 3003);
      tick();
      check("bp_drain", longint'(bus.res_valid), 0);

      // Reset with both stages full discards everything.
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_a[15:0] = 16'sd32767;
      bus.req_b[15:0] = 16'sd32767;
      #1;
      check("full_g0", longint'(bus.req_ready), 1);
      tick();
      tick();
      check("full_valid", longint'(bus.res_valid), 1);
      check("full_data", longint'(bus.res_data), 65534);
      check("full_ready", longint'(bus.req_ready), 0);
      arst_n = 1'b0;
      #1;
      check("arst_valid", longint'(bus.res_valid), 0);
      check("arst_data", longint'(bus.res_data), 0);
      check("arst_ready", longint'(bus.req_ready), 0);
      tick();
      arst_n = 1'b1;
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      tick();
      check("arst_none1", longint'(bus.res_valid), 0);
      tick();
      check("arst_none2", longint'(bus.res_valid), 0);
      bus.req_valid = 4'b1111;
      #1;
      check("arst_ptr0", longint'(bus.req_ready), 1);

      // Lone requester is granted every cycle.
      bus.req_valid = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("solo_ready", longint'(bus.req_ready), 2);
         tick();
         if (c >= 1) begin
            check("solo_id", longint'(bus.res_id), 1);
            check("solo_data", longint'(bus.res_data), 1001);
         end
      end
      bus.req_valid = '0;
      tick();
      check("solo_last", longint'(bus.res_valid), 1);
      tick();
      check("solo_drain", longint'(bus.res_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
